wb_trace_fifo: RTL and testbench

- Trace capture stage directly downstream of the processor top level.
- Consumes the writeback-port outputs (RegWrite, A3, WD3) and, optionally, branch outputs (BranchTaken, ALUResult).
- Timestamps each event and buffers it in a show-ahead FIFO for a host/debug drain port with a valid/ready handshake.
- Used for on-board bring-up and for comparing bench traces against a golden model.

---
 rtl/wb_trace_fifo.sv | 107 ++++++++++
 tb/tb_wb_trace_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// Writeback trace capture: timestamps register-write (and optionally branch) events
// into a show-ahead FIFO drained over a valid/ready port. Branch capture: TRACE_BRANCH_EN.
module wb_trace_fifo #(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clear,
    input  logic                      RegWrite,
    input  logic [3:0]                A3,
    input  logic [31:0]               WD3,
    input  logic                      BranchTaken,
    input  logic [31:0]               ALUResult,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_kind,
    output logic [3:0]                out_reg,
    output logic [31:0]               out_data,
    output logic [TS_WIDTH-1:0]       out_ts,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [7:0]                drop_count
);
    localparam int AW = $clog2(DEPTH);

    logic [TS_WIDTH-1:0]                ts;
    logic [AW-1:0]                      wptr, rptr, br_slot;
    logic [DEPTH-1:0]                   mem_kind;
    logic [DEPTH-1:0][3:0]              mem_reg;
    logic [DEPTH-1:0][31:0]             mem_data;
    logic [DEPTH-1:0][TS_WIDTH-1:0]     mem_ts;

    logic        pop, ev_rw, ev_br, acc_rw, acc_br;
    logic [AW:0] free, count_nxt;
    logic [1:0]  n_push, n_drop;
    logic [8:0]  drop_sum;

    assign pop   = out_valid & out_ready;
    assign ev_rw = en & RegWrite;
`ifdef TRACE_BRANCH_EN
    assign ev_br = en & BranchTaken;
`else
    logic unused_br;
    assign unused_br = ^{BranchTaken, ALUResult};
    assign ev_br     = 1'b0;
`endif

    // A same-cycle pop frees a slot for this cycle's push.
    assign free   = (AW+1)'(DEPTH) - count + (AW+1)'(pop);
    assign acc_rw = ev_rw && (free != '0);
    assign acc_br = ev_br && (acc_rw ? (free > (AW+1)'(1)) : (free != '0));

    assign n_push    = {1'b0, acc_rw} + {1'b0, acc_br};
    assign n_drop    = {1'b0, ev_rw & ~acc_rw} + {1'b0, ev_br & ~acc_br};
    assign count_nxt = count + (AW+1)'(n_push) - (AW+1)'(pop);
    assign drop_sum  = {1'b0, drop_count} + {7'b0, n_drop};
    assign br_slot   = acc_rw ? wptr + AW'(1) : wptr;

    always_ff @(posedge clk) begin
        if (reset) ts <= '0;
        else       ts <= ts + TS_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (pop) rptr <= rptr + AW'(1);
            wptr  <= wptr + AW'(n_push);
            count <= count_nxt;
            if (n_drop != 2'd0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            if (acc_rw) begin
                mem_kind[wptr] <= 1'b0;
                mem_reg[wptr]  <= A3;
                mem_data[wptr] <= WD3;
                mem_ts[wptr]   <= ts;
            end
            if (acc_br) begin
                mem_kind[br_slot] <= 1'b1;
                mem_reg[br_slot]  <= 4'hF;
                mem_data[br_slot] <= ALUResult;
                mem_ts[br_slot]   <= ts;
            end
        end
    end

    assign out_valid = (count != '0);
    assign out_kind  = out_valid ? mem_kind[rptr] : 1'b0;
    assign out_reg   = out_valid ? mem_reg[rptr]  : 4'h0;
    assign out_data  = out_valid ? mem_data[rptr] : 32'h0;
    assign out_ts    = out_valid ? mem_ts[rptr]   : '0;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo; a second instance with TS_WIDTH=4 covers timestamp wrap.
module tb_wb_trace_fifo;
    logic clk = 1'b0;
    logic reset, en, clear, RegWrite, BranchTaken, out_ready;
    logic [3:0]  A3;
    logic [31:0] WD3, ALUResult;

    logic        out_valid, out_kind, overflow;
    logic [3:0]  out_reg;
    logic [31:0] out_data;
    logic [15:0] out_ts;
    logic [4:0]  count;
    logic [7:0]  drop_count;

    logic        v4, k4, ov4;
    logic [3:0]  r4, ts4;
    logic [31:0] d4;
    logic [4:0]  c4;
    logic [7:0]  dc4;

    int checks = 0;
    int failures = 0;
    int tsm = 0;

    always #5 clk = ~clk;

    wb_trace_fifo #(.DEPTH(16), .TS_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .RegWrite(RegWrite),
        .A3(A3), .WD3(WD3), .BranchTaken(BranchTaken), .ALUResult(ALUResult),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_reg(out_reg), .out_data(out_data), .out_ts(out_ts), .count(count),
        .overflow(overflow), .drop_count(drop_count));

    wb_trace_fifo #(.DEPTH(16), .TS_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .RegWrite(RegWrite),
        .A3(A3), .WD3(WD3), .BranchTaken(BranchTaken), .ALUResult(ALUResult),
        .out_valid(v4), .out_ready(out_ready), .out_kind(k4),
        .out_reg(r4), .out_data(d4), .out_ts(ts4), .count(c4),
        .overflow(ov4), .drop_count(dc4));

    // Model timestamp: value of ts during the cycle after this edge.
    task automatic step();
        @(posedge clk);
        if (reset) tsm = 0;
        else       tsm = tsm + 1;
        #1;
    endtask

    task automatic idle();
        reset = 0; en = 1; clear = 0; RegWrite = 0; BranchTaken = 0;
        out_ready = 0; A3 = 0; WD3 = 0; ALUResult = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic write_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            RegWrite = 1; WD3 = base + i; A3 = 4'(i);
            step();
        end
        RegWrite = 0;
    endtask

    task automatic test_reset();
        RegWrite = 1; WD3 = 32'h1234;
        step();
        do_reset();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if ({overflow, drop_count} !== 9'd0) begin failures++; $display("FAIL reset_err got=%b/%0d exp=0/0", overflow, drop_count); end
        checks++; if ({out_kind, out_reg, out_data, out_ts} !== 53'd0) begin failures++; $display("FAIL reset_head got=%0h exp=0", {out_kind, out_reg, out_data, out_ts}); end
    endtask

    task automatic test_basic();
        do_reset();
        repeat (5) step();
        RegWrite = 1; A3 = 4'd3; WD3 = 32'hDEADBEEF;
        step();
        RegWrite = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_kind !== 1'b0 || out_reg !== 4'd3) begin failures++; $display("FAIL basic_kindreg got=%b/%0h exp=0/3", out_kind, out_reg); end
        checks++; if (out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_data got=%h exp=deadbeef", out_data); end
        checks++; if (out_ts !== 16'd5) begin failures++; $display("FAIL basic_ts got=%0d exp=5", out_ts); end
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
        RegWrite = 1; en = 0; WD3 = 32'h77;
        step();
        RegWrite = 0; en = 1;
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL en0_count got=%0d exp=1", count); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        write_n(18, 0);
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL fill_drops got=%0d exp=2", drop_count); end
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin failures++; $display("FAIL drain_%0d got=%b/%0d exp=1/%0d", i, out_valid, out_data, i); end
            step();
        end
        out_ready = 0;
        checks++; if (count !== 5'd0 || out_valid !== 1'b0 || out_data !== 32'd0) begin failures++; $display("FAIL drain_empty got=%0d/%b/%0h exp=0/0/0", count, out_valid, out_data); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        write_n(16, 100);
        RegWrite = 1; WD3 = 200; out_ready = 1;
        step();
        RegWrite = 0;
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL fpp_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL fpp_nodrop got=%b/%0d exp=0/0", overflow, drop_count); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_data !== ((i < 15) ? 32'(101 + i) : 32'd200)) begin failures++; $display("FAIL fpp_order_%0d got=%0d exp=%0d", i, out_data, (i < 15) ? 101 + i : 200); end
            step();
        end
        out_ready = 0;
    endtask

    task automatic test_clear();
        logic [15:0] t;
        do_reset();
        write_n(23, 0);
        out_ready = 1;
        repeat (7) step();
        out_ready = 0;
        checks++; if (count !== 5'd9 || overflow !== 1'b1 || drop_count !== 8'd7) begin failures++; $display("FAIL clr_pre got=%0d/%b/%0d exp=9/1/7", count, overflow, drop_count); end
        clear = 1; RegWrite = 1; WD3 = 32'hAA;
        step();
        clear = 0; RegWrite = 0;
        checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL clr_count got=%0d/%b exp=0/0", count, out_valid); end
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL clr_err got=%b/%0d exp=0/0", overflow, drop_count); end
        t = 16'(tsm);
        RegWrite = 1; WD3 = 32'd55;
        step();
        RegWrite = 0;
        checks++; if (out_ts !== t || out_data !== 32'd55) begin failures++; $display("FAIL clr_ts got=%0d/%0d exp=%0d/55", out_ts, out_data, t); end
    endtask

    task automatic test_ts_wrap();
        do_reset();
        repeat (15) step();
        write_n(2, 40);
        RegWrite = 1; en = 0;
        step();
        RegWrite = 0; en = 1;
        checks++; if (c4 !== 5'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", c4); end
        checks++; if (ts4 !== 4'd15 || out_ts !== 16'd15) begin failures++; $display("FAIL wrap_ts0 got=%0d/%0d exp=15/15", ts4, out_ts); end
        out_ready = 1;
        step();
        checks++; if (ts4 !== 4'd0 || out_ts !== 16'd16 || d4 !== 32'd41) begin failures++; $display("FAIL wrap_ts1 got=%0d/%0d/%0d exp=0/16/41", ts4, out_ts, d4); end
        step();
        out_ready = 0;
        checks++; if (c4 !== 5'd0 || count !== 5'd0) begin failures++; $display("FAIL wrap_empty got=%0d/%0d exp=0/0", c4, count); end
    endtask

    task automatic test_branch();
        logic [15:0] t;
        do_reset();
`ifdef TRACE_BRANCH_EN
        t = 16'(tsm);
        RegWrite = 1; A3 = 4'd2; WD3 = 32'd9; BranchTaken = 1; ALUResult = 32'h40;
        step();
        RegWrite = 0; BranchTaken = 0;
        checks++; if (count !== 5'd2) begin failures++; $display("FAIL br_count got=%0d exp=2", count); end
        checks++; if ({out_kind, out_reg, out_data, out_ts} !== {1'b0, 4'd2, 32'd9, t}) begin failures++; $display("FAIL br_first got=%b/%h/%h/%0d exp=0/2/9/%0d", out_kind, out_reg, out_data, out_ts, t); end
        out_ready = 1;
        step();
        out_ready = 0;
        checks++; if ({out_kind, out_reg, out_data, out_ts} !== {1'b1, 4'hF, 32'h40, t}) begin failures++; $display("FAIL br_second got=%b/%h/%h/%0d exp=1/f/40/%0d", out_kind, out_reg, out_data, out_ts, t); end
        do_reset();
        write_n(15, 0);
        RegWrite = 1; A3 = 4'd2; WD3 = 32'd9; BranchTaken = 1; ALUResult = 32'h40;
        step();
        checks++; if (count !== 5'd16 || drop_count !== 8'd1 || overflow !== 1'b1) begin failures++; $display("FAIL br_one_slot got=%0d/%0d/%b exp=16/1/1", count, drop_count, overflow); end
        step();
        RegWrite = 0; BranchTaken = 0;
        checks++; if (drop_count !== 8'd3) begin failures++; $display("FAIL br_zero_slot got=%0d exp=3", drop_count); end
        out_ready = 1;
        repeat (15) step();
        out_ready = 0;
        checks++; if (count !== 5'd1 || out_kind !== 1'b0 || out_data !== 32'd9) begin failures++; $display("FAIL br_kept got=%0d/%b/%0d exp=1/0/9", count, out_kind, out_data); end
`else
        BranchTaken = 1; ALUResult = 32'h40;
        step();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL br_ignored got=%0d exp=0", count); end
        RegWrite = 1; A3 = 4'd2; WD3 = 32'd9;
        step();
        RegWrite = 0; BranchTaken = 0;
        t = 16'(tsm - 1);
        checks++; if (count !== 5'd1 || {out_kind, out_reg, out_data, out_ts} !== {1'b0, 4'd2, 32'd9, t}) begin failures++; $display("FAIL br_rw_only got=%0d/%b/%h/%0d exp=1/0/9/%0d", count, out_kind, out_data, out_ts, t); end
`endif
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_push_pop();
        test_clear();
        test_ts_wrap();
        test_branch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
